// File: rtl/adc_zero_cross_if.sv
// Sample/result bundle between the dual-channel ADC front end and adc_zero_cross.
// The master side drives samples; the slave side (adc_zero_cross) returns square waves and status.
interface adc_zero_cross_if #(
  parameter int DW = 10
);
  logic          sample_valid;
  logic [DW-1:0] adc_a;
  logic [DW-1:0] adc_b;
  logic          sig_a;
  logic          sig_b;
  logic [1:0]    amp_ok;
  logic          rect_wave_det;
  logic [DW-1:0] mid_a;
  logic [DW-1:0] mid_b;

  modport master (
    output sample_valid, adc_a, adc_b,
    input  sig_a, sig_b, amp_ok, rect_wave_det, mid_a, mid_b
  );

  modport slave (
    input  sample_valid, adc_a, adc_b,
    output sig_a, sig_b, amp_ok, rect_wave_det, mid_a, mid_b
  );
endinterface

// File: rtl/adc_zero_cross.sv
// Dual-channel adaptive-midpoint hysteresis comparator with amplitude and rectangular-wave detection.
// Optional feature: define ZC_DEGLITCH_EN to require DEGLITCH_N consecutive samples before a toggle.
module adc_zero_cross #(
  parameter int DW          = 10,
  parameter int WIN_LEN     = 4096,
  parameter int HYST        = 8,
  parameter int MIN_AMP     = 32,
`ifdef ZC_DEGLITCH_EN
  parameter int DEGLITCH_N  = 3,
`endif
  parameter int RAIL_MARGIN = 16
) (
  input  logic             clk,
  input  logic             rst,
  adc_zero_cross_if.slave  bus
);
  localparam int WCW = $clog2(WIN_LEN);
  localparam int RCW = $clog2(WIN_LEN + 1);
  localparam logic [DW-1:0]  MID_RST = {1'b1, {(DW-1){1'b0}}};
  localparam logic [RCW-1:0] RAIL_TH = RCW'((WIN_LEN * 3) >> 2);
`ifdef ZC_DEGLITCH_EN
  localparam int DGW = $clog2(DEGLITCH_N + 1);
`endif

  typedef enum logic {ST_LOW, ST_HIGH} cmp_state_e;

  logic [WCW-1:0]      r_win_cnt;
  logic                w_close;
  logic                r_rect_wave_det;
  logic [1:0]          w_sig, w_amp_ok, w_amp_nxt, w_rect_nxt;
  logic [1:0][DW-1:0]  w_mid;

  assign w_close = bus.sample_valid && (r_win_cnt == WCW'(WIN_LEN - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_cnt       <= '0;
      r_rect_wave_det <= 1'b0;
    end else if (bus.sample_valid) begin
      r_win_cnt <= w_close ? '0 : r_win_cnt + WCW'(1);
      if (w_close)
        r_rect_wave_det <= &{w_rect_nxt, w_amp_nxt};
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [DW-1:0]  w_s;
    logic [DW-1:0]  r_mid, r_max, r_min, r_prev_max, r_prev_min;
    logic [RCW-1:0] r_rail_cnt, w_rail_nxt;
    logic           r_amp_ok, w_rail_hit, w_beyond;
    cmp_state_e     r_state, w_state_nxt;
    logic [DW:0]    w_hi_sum, w_mid_sum;
    logic [DW-1:0]  w_hi_th, w_lo_th, w_max_nxt, w_min_nxt, w_dist_max, w_dist_min;
`ifdef ZC_DEGLITCH_EN
    logic [DGW-1:0] r_dg_cnt, w_dg_nxt;
`endif

    assign w_s = (ch == 0) ? bus.adc_a : bus.adc_b;

    assign w_hi_sum = {1'b0, r_mid} + (DW+1)'(HYST);
    assign w_hi_th  = w_hi_sum[DW] ? '1 : w_hi_sum[DW-1:0];
    assign w_lo_th  = (r_mid >= DW'(HYST)) ? r_mid - DW'(HYST) : '0;

    assign w_max_nxt = (w_s > r_max) ? w_s : r_max;
    assign w_min_nxt = (w_s < r_min) ? w_s : r_min;
    assign w_mid_sum = {1'b0, w_max_nxt} + {1'b0, w_min_nxt};

    // Rail proximity is judged against the previous window's extremes, not the running ones.
    assign w_dist_max = (w_s > r_prev_max) ? w_s - r_prev_max : r_prev_max - w_s;
    assign w_dist_min = (w_s > r_prev_min) ? w_s - r_prev_min : r_prev_min - w_s;
    assign w_rail_hit = (w_dist_max <= DW'(RAIL_MARGIN)) || (w_dist_min <= DW'(RAIL_MARGIN));
    assign w_rail_nxt = (w_rail_hit && (r_rail_cnt != RCW'(WIN_LEN))) ? r_rail_cnt + RCW'(1)
                                                                      : r_rail_cnt;

    assign w_amp_nxt[ch]  = (w_max_nxt - w_min_nxt) >= DW'(MIN_AMP);
    assign w_rect_nxt[ch] = w_rail_nxt >= RAIL_TH;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_mid      <= MID_RST;
        r_max      <= '0;
        r_min      <= '1;
        r_prev_max <= '0;
        r_prev_min <= '1;
        r_rail_cnt <= '0;
        r_amp_ok   <= 1'b0;
      end else if (w_close) begin
        r_mid      <= w_mid_sum[DW:1];
        r_amp_ok   <= w_amp_nxt[ch];
        r_prev_max <= w_max_nxt;
        r_prev_min <= w_min_nxt;
        r_max      <= '0;
        r_min      <= '1;
        r_rail_cnt <= '0;
      end else if (bus.sample_valid) begin
        r_max      <= w_max_nxt;
        r_min      <= w_min_nxt;
        r_rail_cnt <= w_rail_nxt;
      end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
      w_state_nxt = r_state;
      w_beyond    = (r_state == ST_LOW) ? (w_s >= w_hi_th) : (w_s <= w_lo_th);
`ifdef ZC_DEGLITCH_EN
      w_dg_nxt = '0;
      if (w_beyond) begin
        if (r_dg_cnt == DGW'(DEGLITCH_N - 1))
          w_state_nxt = (r_state == ST_LOW) ? ST_HIGH : ST_LOW;
        else
          w_dg_nxt = r_dg_cnt + DGW'(1);
      end
`else
      if (w_beyond)
        w_state_nxt = (r_state == ST_LOW) ? ST_HIGH : ST_LOW;
`endif
      if (!r_amp_ok) begin
        w_state_nxt = ST_LOW;
`ifdef ZC_DEGLITCH_EN
        w_dg_nxt = '0;
`endif
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= ST_LOW;
`ifdef ZC_DEGLITCH_EN
        r_dg_cnt <= '0;
`endif
      end else if (bus.sample_valid) begin
        r_state <= w_state_nxt;
`ifdef ZC_DEGLITCH_EN
        r_dg_cnt <= w_dg_nxt;
`endif
      end
    end

    // Gating by amp_ok drops sig the moment a channel loses its swing.
    assign w_sig[ch]    = (r_state == ST_HIGH) && r_amp_ok;
    assign w_amp_ok[ch] = r_amp_ok;
    assign w_mid[ch]    = r_mid;
  end

  assign bus.sig_a         = w_sig[0];
  assign bus.sig_b         = w_sig[1];
  assign bus.amp_ok        = w_amp_ok;
  assign bus.rect_wave_det = r_rect_wave_det;
  assign bus.mid_a         = w_mid[0];
  assign bus.mid_b         = w_mid[1];
endmodule
